// File: rtl/detector_stream_ctrl.sv
// Detector front end: Avalon-MM control/status slave plus hsync/vsync to Avalon-ST framer.
// Optional test-pattern replacement of pixel data is built when DETECTOR_TPAT_EN is defined.
module detector_stream_ctrl #(
    parameter int DATA_WIDTH = 14,
    parameter int AD_DELAY   = 5,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            av_address,
    input  logic                  av_read,
    input  logic                  av_write,
    input  logic [31:0]           av_writedata,
    output logic [31:0]           av_readdata,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dd_nrst,
    output logic                  dd_i2cad,
    input  logic                  dd_hsync,
    input  logic                  dd_vsync,
    input  logic [DATA_WIDTH-1:0] dd_video
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, PAD} state_t;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
        logic pad;
`ifdef DETECTOR_TPAT_EN
        logic [DATA_WIDTH-1:0] tp;
`endif
    } beat_t;

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = 1;
    localparam logic [DIM_WIDTH-1:0] DIM_MAX = '1;
    // Sticky error flag positions; they read back on STATUS[4:1].
    localparam int F_SHORT_LINE  = 0;
    localparam int F_LONG_LINE   = 1;
    localparam int F_SHORT_FRAME = 2;
    localparam int F_LONG_FRAME  = 3;

    state_t                 state, next_state;
    logic                   go, i2cad;
    logic [DIM_WIDTH-1:0]   width, height, col, row;
    logic [31:0]            frame_cnt;
    logic [DATA_WIDTH-1:0]  vtemp;
    logic [3:0]             status_q, set_flags;
    logic                   hsync_q, vsync_q, sop_done;
    logic                   frame_start, col_inc, row_inc, cnt_inc;
    logic                   tpat_rd;
    logic [31:0]            rd_mux;
    logic [DATA_WIDTH-1:0]  pix_data;
    beat_t                  beat, beat_dly;

    wire vsync_rise = dd_vsync & ~vsync_q;
    wire vsync_fall = ~dd_vsync & vsync_q;
    wire hsync_fall = ~dd_hsync & hsync_q;
    wire pixel      = dd_hsync & dd_vsync;
    wire in_frame   = (state != IDLE);
    wire wr_status  = av_write && (av_address == 3'd2);
    wire unused_wdata = ^av_writedata;

    function automatic logic [DIM_WIDTH-1:0] sat_inc(input logic [DIM_WIDTH-1:0] v);
        return (v == DIM_MAX) ? v : v + DIM_ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state   <= next_state;
            hsync_q <= dd_hsync;
            vsync_q <= dd_vsync;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        next_state  = state;
        beat        = '0;
        set_flags   = '0;
        frame_start = 1'b0;
        col_inc     = 1'b0;
        row_inc     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (vsync_rise && go && width != '0 && height != '0) begin
                    next_state  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (vsync_fall) begin
                    // Frame ended early: close the packet with a zero-data EOP beat.
                    next_state               = PAD;
                    beat.valid               = 1'b1;
                    beat.eop                 = 1'b1;
                    beat.pad                 = 1'b1;
                    beat.sop                 = ~sop_done;
                    set_flags[F_SHORT_FRAME] = 1'b1;
                    cnt_inc                  = 1'b1;
                end else if (pixel) begin
                    col_inc = 1'b1;
                    if (row >= height) begin
                        set_flags[F_LONG_FRAME] = 1'b1;
                    end else if (col >= width) begin
                        set_flags[F_LONG_LINE] = 1'b1;
                    end else begin
                        beat.valid = 1'b1;
                        beat.sop   = (col == '0) && (row == '0);
                        beat.eop   = (col == width - DIM_ONE) && (row == height - DIM_ONE);
`ifdef DETECTOR_TPAT_EN
                        beat.tp    = DATA_WIDTH'(32'(row) + 32'(col));
`endif
                        if (beat.eop) begin
                            next_state = DONE;
                            cnt_inc    = 1'b1;
                        end
                    end
                end else if (hsync_fall && col != '0) begin
                    row_inc = 1'b1;
                    if (col < width) set_flags[F_SHORT_LINE] = 1'b1;
                end
            end
            DONE: begin
                if (vsync_fall)  next_state = IDLE;
                else if (pixel) set_flags[F_LONG_FRAME] = 1'b1;
            end
            PAD:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            col      <= '0;
            row      <= '0;
            sop_done <= 1'b0;
        end else begin
            if (row_inc) begin
                row <= sat_inc(row);
                col <= '0;
            end else if (col_inc) begin
                col <= sat_inc(col);
            end
            if (beat.valid) sop_done <= 1'b1;
        end
    end

    // Framing control waits out the ADC latency so it lines up with the matching sample.
    generate
        if (AD_DELAY == 0) begin : g_no_delay
            assign beat_dly = beat;
        end else begin : g_delay
            beat_t pipe [AD_DELAY];
            // NOTE: this delay line is reset explicitly so a frame aborted by reset never leaks a beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < AD_DELAY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= beat;
                    for (int i = 1; i < AD_DELAY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign beat_dly = pipe[AD_DELAY-1];
        end
    endgenerate

`ifdef DETECTOR_TPAT_EN
    logic tpat;
    assign tpat_rd  = tpat;
    assign pix_data = tpat ? beat_dly.tp : dd_video;
`else
    assign tpat_rd  = 1'b0;
    assign pix_data = dd_video;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid         <= 1'b0;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= 1'b0;
            dout_data          <= '0;
        end else begin
            dout_valid         <= beat_dly.valid;
            dout_startofpacket <= beat_dly.valid & beat_dly.sop;
            dout_endofpacket   <= beat_dly.valid & beat_dly.eop;
            if (beat_dly.valid) dout_data <= beat_dly.pad ? '0 : pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            go        <= 1'b0;
            i2cad     <= 1'b0;
            width     <= '0;
            height    <= '0;
            frame_cnt <= '0;
            vtemp     <= '0;
            status_q  <= '0;
`ifdef DETECTOR_TPAT_EN
            tpat      <= 1'b0;
`endif
        end else begin
            if (av_write) begin
                case (av_address)
                    3'd0: begin
                        go <= av_writedata[0];
`ifdef DETECTOR_TPAT_EN
                        tpat <= av_writedata[4];
`endif
                    end
                    3'd3:    i2cad  <= av_writedata[0];
                    3'd4:    width  <= av_writedata[DIM_WIDTH-1:0];
                    3'd5:    height <= av_writedata[DIM_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (av_write && av_address == 3'd6) frame_cnt <= '0;
            else if (cnt_inc)                   frame_cnt <= frame_cnt + 32'd1;
            if (vsync_rise) vtemp <= dd_video;
            // A new error in the same cycle as its W1C keeps the flag set.
            status_q <= (status_q & ~(wr_status ? av_writedata[4:1] : 4'b0)) | set_flags;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (av_address)
            3'd0:    rd_mux = {27'b0, tpat_rd, 3'b0, go};
            3'd1:    rd_mux = 32'(vtemp);
            3'd2:    rd_mux = {27'b0, status_q, in_frame};
            3'd3:    rd_mux = {31'b0, i2cad};
            3'd4:    rd_mux = 32'(width);
            3'd5:    rd_mux = 32'(height);
            3'd6:    rd_mux = frame_cnt;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)          av_readdata <= '0;
        else if (av_read) av_readdata <= rd_mux;
        else              av_readdata <= '0;
    end

    assign dd_nrst  = go;
    assign dd_i2cad = i2cad;
endmodule

// File: tb/tb_detector_stream_ctrl.sv
// Directed-vector bench for detector_stream_ctrl with WIDTH=4, HEIGHT=2, AD_DELAY=2, DATA_WIDTH=14.
// Video input is a free-running cycle index, so every beat's data identifies the sample edge it came from.
module tb_detector_stream_ctrl;
    localparam int DW = 14;
    localparam int AD = 2;
`ifdef DETECTOR_TPAT_EN
    localparam logic [31:0] CTRL_TPAT_RD = 32'h11;
`else
    localparam logic [31:0] CTRL_TPAT_RD = 32'h01;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    av_address = '0;
    logic          av_read = 1'b0, av_write = 1'b0;
    logic [31:0]   av_writedata = '0;
    logic [31:0]   av_readdata;
    logic          sop, eop, valid;
    logic [DW-1:0] data;
    logic          dd_nrst, dd_i2cad;
    logic          dd_hsync = 1'b0, dd_vsync = 1'b0;
    logic [DW-1:0] dd_video;
    logic          vid_force = 1'b0;
    logic [DW-1:0] vid_val = '0;
    int            cyc = 0;
    int            fall_p = 0;
    int            n_vec = 0, n_bad = 0;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
        int            cyc;
    } rec_t;

    rec_t mon_q[$];
    rec_t exp_q[$];
    int   pix_p[$];

    detector_stream_ctrl #(.DATA_WIDTH(DW), .AD_DELAY(AD), .DIM_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_readdata(av_readdata),
        .dout_startofpacket(sop), .dout_endofpacket(eop), .dout_valid(valid), .dout_data(data),
        .dd_nrst(dd_nrst), .dd_i2cad(dd_i2cad),
        .dd_hsync(dd_hsync), .dd_vsync(dd_vsync), .dd_video(dd_video)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // The sample taken at posedge number p carries the value p.
    assign dd_video = vid_force ? vid_val : DW'(cyc + 1);

    always @(negedge clk)
        if (valid) mon_q.push_back('{sop, eop, data, cyc});

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic av_wr(input logic [2:0] a, input logic [31:0] d);
        av_address = a; av_writedata = d; av_write = 1'b1;
        step();
        av_write = 1'b0;
    endtask

    task automatic reg_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        av_address = a; av_read = 1'b1;
        step();
        av_read = 1'b0;
        check(tag, av_readdata, exp);
    endtask

    task automatic vs_rise();
        pix_p.delete(); mon_q.delete(); exp_q.delete();
        dd_vsync = 1'b1;
        step(2);
    endtask

    task automatic vs_fall();
        dd_vsync = 1'b0;
        fall_p = cyc + 1;
        step(AD + 4);
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) begin
            dd_hsync = 1'b1;
            pix_p.push_back(cyc + 1);
            step();
        end
        dd_hsync = 1'b0;
        step(2);
    endtask

    // A pixel sampled at edge p is emitted at p+AD carrying the sample from edge p+AD.
    task automatic exp_pix(input int idx, input logic s, input logic e);
        exp_q.push_back('{s, e, DW'(pix_p[idx] + AD), pix_p[idx] + AD});
    endtask

    task automatic exp_pad(input logic s);
        exp_q.push_back('{s, 1'b1, '0, fall_p + AD});
    endtask

    task automatic cmp_frame(input string tag);
        check({tag, " beats"}, 64'(mon_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < mon_q.size())
                check($sformatf("%s beat%0d {sop,eop,data,cyc}", tag, i),
                      {mon_q[i].sop, mon_q[i].eop, mon_q[i].data, mon_q[i].cyc},
                      {exp_q[i].sop, exp_q[i].eop, exp_q[i].data, exp_q[i].cyc});
    endtask

    initial begin
        step(3);
        check("rst valid", valid, 1'b0);
        check("rst sop/eop", {sop, eop}, 2'b00);
        check("rst data", data, 0);
        check("rst dd_nrst/i2cad", {dd_nrst, dd_i2cad}, 2'b00);
        rst = 1'b0;
        step();
        reg_chk("rst WIDTH", 3'd4, 0);
        reg_chk("rst STATUS", 3'd2, 0);
        reg_chk("rst FRAME_CNT", 3'd6, 0);

        // Zero geometry: go set but the FSM must stay idle.
        av_wr(3'd0, 32'h1);
        vs_rise();
        reg_chk("w0 in_frame", 3'd2, 0);
        line(4);
        vs_fall();
        check("w0 beats", 64'(mon_q.size()), 0);

        av_wr(3'd4, 4); av_wr(3'd5, 2); av_wr(3'd3, 1); av_wr(3'd0, 32'h11);
        check("cfg dd_nrst", dd_nrst, 1'b1);
        check("cfg dd_i2cad", dd_i2cad, 1'b1);
        reg_chk("cfg CTRL", 3'd0, CTRL_TPAT_RD);
        av_wr(3'd0, 32'h1);
        reg_chk("cfg WIDTH", 3'd4, 4);
        reg_chk("cfg HEIGHT", 3'd5, 2);
        reg_chk("cfg reg7", 3'd7, 0);

        // Full frame.
        vs_rise();
        reg_chk("t1 in_frame", 3'd2, 1);
        line(4); line(4);
        vs_fall();
        for (int i = 0; i < 8; i++) exp_pix(i, i == 0, i == 7);
        cmp_frame("t1");
        reg_chk("t1 FRAME_CNT", 3'd6, 1);
        reg_chk("t1 STATUS", 3'd2, 0);

        // Short frame padded with a zero EOP beat.
        vs_rise();
        line(4);
        vs_fall();
        for (int i = 0; i < 4; i++) exp_pix(i, i == 0, 1'b0);
        exp_pad(1'b0);
        cmp_frame("t2");
        reg_chk("t2 STATUS", 3'd2, 32'h8);
        av_wr(3'd2, 32'h8);
        reg_chk("t2 STATUS w1c", 3'd2, 0);
        reg_chk("t2 FRAME_CNT", 3'd6, 2);

        // Long line then long frame.
        vs_rise();
        line(6); line(4); line(2);
        vs_fall();
        for (int i = 0; i < 4; i++) exp_pix(i, i == 0, 1'b0);
        for (int i = 6; i < 10; i++) exp_pix(i, 1'b0, i == 9);
        cmp_frame("t3");
        reg_chk("t3 STATUS", 3'd2, 32'h14);
        av_wr(3'd2, 32'h4);
        reg_chk("t3 STATUS partial w1c", 3'd2, 32'h10);
        av_wr(3'd2, 32'h10);
        reg_chk("t3 STATUS w1c", 3'd2, 0);

        // Short line: no pad, frame still ends at col 3 of row 1.
        vs_rise();
        line(2); line(4);
        vs_fall();
        for (int i = 0; i < 6; i++) exp_pix(i, i == 0, i == 5);
        cmp_frame("t3s");
        reg_chk("t3s STATUS", 3'd2, 32'h2);
        av_wr(3'd2, 32'h2);

        // go cleared mid-frame: frame completes, next vsync is ignored.
        vs_rise();
        line(4);
        av_wr(3'd0, 32'h0);
        check("t4 dd_nrst", dd_nrst, 1'b0);
        line(4);
        vs_fall();
        for (int i = 0; i < 8; i++) exp_pix(i, i == 0, i == 7);
        cmp_frame("t4");
        reg_chk("t4 FRAME_CNT", 3'd6, 5);
        vs_rise();
        line(4);
        vs_fall();
        check("t4 no frame beats", 64'(mon_q.size()), 0);
        reg_chk("t4 STATUS", 3'd2, 0);
        av_wr(3'd6, 32'hDEAD);
        reg_chk("t4 FRAME_CNT clr", 3'd6, 0);

        // VTEMP captures video on vsync rise with go=0.
        vid_val = 14'h1ABC; vid_force = 1'b1; dd_vsync = 1'b1;
        step();
        vid_force = 1'b0;
        step();
        dd_vsync = 1'b0;
        step(2);
        reg_chk("t6 VTEMP", 3'd1, 32'h1ABC);

        // Reset mid-frame: pending beats are discarded.
        av_wr(3'd0, 32'h1);
        vs_rise();
        dd_hsync = 1'b1;
        step(2);
        rst = 1'b1; dd_hsync = 1'b0;
        step();
        check("t5 valid", valid, 1'b0);
        check("t5 sop/eop", {sop, eop}, 2'b00);
        check("t5 dd_nrst", dd_nrst, 1'b0);
        rst = 1'b0;
        step(AD + 4);
        check("t5 beats", 64'(mon_q.size()), 0);
        reg_chk("t5 WIDTH", 3'd4, 0);
        dd_vsync = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
